// File: rtl/preif_fetch_ctrl.sv
// rtl/preif_fetch_ctrl.sv - pre-IF fetch sequencer; define PC_ALIGN_CHECK_EN to report misaligned PCs via if_adel
module preif_fetch_ctrl #(
  parameter logic [31:0] RST_PC  = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PREIF_PC,
  output logic        PREIF_Wr,
  output logic [31:0] PREIF_NPC,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [31:0] icache_req_addr,
  input  logic        icache_rsp_valid,
  input  logic [31:0] icache_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] req_pc;
  logic        can_load;
  logic        misaligned;
  logic        req_fire;
  logic        load_rsp;
  logic        load_adel;

  // The IF register can take a new word when it is empty or being drained this cycle.
  assign can_load = !if_valid || if_ready;

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = (PREIF_PC[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Request depends only on state and the IF register, never on redirect_valid.
  assign icache_req_valid = (state == REQ) && can_load && !misaligned;
  assign icache_req_addr  = PREIF_PC;
  assign req_fire         = icache_req_valid && icache_req_ready;

  // Next-state, PC update and IF-load decode; redirect overrides everything.
  always_comb begin
    state_nxt = state;
    PREIF_Wr  = 1'b0;
    PREIF_NPC = PREIF_PC + PC_STEP;
    load_rsp  = 1'b0;
    load_adel = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (req_fire) begin
          PREIF_Wr  = 1'b1;
          state_nxt = WAIT;
        end
        load_adel = misaligned && can_load;
      end
      WAIT: begin
        if (icache_rsp_valid) begin
          load_rsp  = 1'b1;
          state_nxt = REQ;
        end
      end
      DISCARD: begin
        if (icache_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      PREIF_Wr  = 1'b1;
      PREIF_NPC = redirect_pc;
      load_rsp  = 1'b0;
      load_adel = 1'b0;
      case (state)
        REQ:           state_nxt = req_fire ? DISCARD : REQ;
        WAIT, DISCARD: state_nxt = icache_rsp_valid ? REQ : DISCARD;
        default:       state_nxt = REQ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Remember the fetched PC: PREIF_PC has already advanced when the response returns.
  always_ff @(posedge clk) begin
    if (rst)           req_pc <= RST_PC;
    else if (req_fire) req_pc <= PREIF_PC;
  end

  // IF output register: flush on redirect, load on response or address error, drain on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= RST_PC;
      if_instr <= 32'h0;
      if_adel  <= 1'b0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (load_rsp) begin
      if_valid <= 1'b1;
      if_pc    <= req_pc;
      if_instr <= icache_rsp_data;
      if_adel  <= 1'b0;
    end else if (load_adel) begin
      if_valid <= 1'b1;
      if_pc    <= PREIF_PC;
      if_instr <= 32'h0;
      if_adel  <= 1'b1;
    end else if (if_ready) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_preif_fetch_ctrl.sv
// tb/tb_preif_fetch_ctrl.sv - scoreboard bench for preif_fetch_ctrl with PC register and I-cache models
module tb_preif_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_reg;
  logic        PREIF_Wr;
  logic [31:0] PREIF_NPC;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_rsp_valid;
  logic [31:0] icache_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cache_lat = 0;
  logic [31:0] exp_q[$];
  int          pop_cyc[$];

  preif_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .PREIF_PC         (pc_reg),
    .PREIF_Wr         (PREIF_Wr),
    .PREIF_NPC        (PREIF_NPC),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .icache_req_valid (icache_req_valid),
    .icache_req_ready (icache_req_ready),
    .icache_req_addr  (icache_req_addr),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_data  (icache_rsp_data),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .if_adel          (if_adel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PC register counterpart
  always @(posedge clk) begin
    if (rst)           pc_reg <= RST_PC;
    else if (PREIF_Wr) pc_reg <= PREIF_NPC;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // I-cache model: one response cache_lat cycles after the cycle following acceptance
  initial begin
    logic        hs_seen;
    logic        rst_s;
    logic [31:0] hs_addr;
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = 32'h0;
    pend = 1'b0;
    pend_addr = 32'h0;
    cnt = 0;
    forever begin
      @(negedge clk);
      rst_s   = rst;
      hs_seen = icache_req_valid && icache_req_ready && !rst;
      hs_addr = icache_req_addr;
      @(posedge clk);
      #2;
      icache_rsp_valid = 1'b0;
      if (rst_s) begin
        pend = 1'b0;
      end else begin
        if (hs_seen) begin
          pend = 1'b1;
          pend_addr = hs_addr;
          cnt = cache_lat;
        end
        if (pend) begin
          if (cnt == 0) begin
            icache_rsp_valid = 1'b1;
            icache_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: every accepted IF output is popped against the expected queue
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && if_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: actual pc %h required no output", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", if_pc, e);
          check("out_instr", if_instr, mem_word(e));
          check("out_adel", {31'b0, if_adel}, 32'h0);
        end
      end
    end
  end

  task automatic wait_hs(input string name, input logic [31:0] exp_addr, output int at);
    bit found;
    found = 1'b0;
    at = -1;
    for (int g = 0; g < 100 && !found; g++) begin
      @(negedge clk);
      if (icache_req_valid && icache_req_ready) begin
        found = 1'b1;
        at = cyc;
      end
    end
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: actual no request in 100 cycles required addr %h", name, exp_addr);
    end else begin
      check(name, icache_req_addr, exp_addr);
    end
  endtask

  task automatic drain(input string name);
    for (int g = 0; g < 200 && exp_q.size() != 0; g++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: actual %0d outputs missing required 0", name, exp_q.size());
      exp_q.delete();
    end
    #1 if_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int r;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    icache_req_ready = 1'b1;
    if_ready = 1'b1;
    cache_lat = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_pc", if_pc, RST_PC);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_adel", {31'b0, if_adel}, 32'h0);
    check("rst_wr", {31'b0, PREIF_Wr}, 32'h0);
    check("rst_req_valid", {31'b0, icache_req_valid}, 32'h0);

    // sequential fetch, zero-wait cache
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hBFC0_0004);
    exp_q.push_back(32'hBFC0_0008);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", {31'b0, icache_req_valid}, 32'h0);
    @(negedge clk);
    check("first_req_valid", {31'b0, icache_req_valid}, 32'h1);
    check("first_req_addr", icache_req_addr, 32'hBFC0_0000);
    drain("seq_drain");
    if (pop_cyc.size() >= 3) begin
      check("throughput_gap0", pop_cyc[1] - pop_cyc[0], 32'd2);
      check("throughput_gap1", pop_cyc[2] - pop_cyc[1], 32'd2);
    end else begin
      check("throughput_pops", pop_cyc.size(), 32'd3);
    end

    // downstream stall for 5 cycles
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, if_valid}, 32'h1);
      check("stall_pc", if_pc, 32'hBFC0_000C);
      check("stall_instr", if_instr, mem_word(32'hBFC0_000C));
      check("stall_no_req", {31'b0, icache_req_valid}, 32'h0);
      @(negedge clk);
    end
    exp_q.push_back(32'hBFC0_000C);
    exp_q.push_back(32'hBFC0_0010);
    @(posedge clk);
    #1 if_ready = 1'b1;
    drain("resume_drain");

    // redirect while waiting, stale response 3 cycles later
    repeat (2) @(negedge clk);
    cache_lat = 3;
    exp_q.push_back(32'hBFC0_0014);
    @(posedge clk);
    #1 if_ready = 1'b1;
    wait_hs("wait_fetch_addr", 32'hBFC0_0018, at);
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    @(negedge clk);
    r = cyc;
    check("redir_wait_wr", {31'b0, PREIF_Wr}, 32'h1);
    check("redir_wait_npc", PREIF_NPC, 32'h8000_0100);
    check("redir_wait_no_req", {31'b0, icache_req_valid}, 32'h0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    exp_q.push_back(32'h8000_0100);
    @(negedge clk);
    check("redir_flush_valid", {31'b0, if_valid}, 32'h0);
    wait_hs("redir_target_addr", 32'h8000_0100, at);
    check("redir_discard_len", at - r, 32'd4);
    drain("redir_drain");

    // redirect in the same cycle as the response
    repeat (2) @(negedge clk);
    cache_lat = 0;
    exp_q.push_back(32'h8000_0104);
    @(posedge clk);
    #1 if_ready = 1'b1;
    wait_hs("rsp_fetch_addr", 32'h8000_0108, at);
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    r = cyc;
    check("redir_rsp_wr", {31'b0, PREIF_Wr}, 32'h1);
    check("redir_rsp_npc", PREIF_NPC, 32'hFFFF_FFF8);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    wait_hs("redir_rsp_target", 32'hFFFF_FFF8, at);
    check("redir_rsp_to_req", at - r, 32'd1);

    // PC wrap
    wait_hs("wrap_fetch_addr", 32'hFFFF_FFFC, at);
    check("wrap_npc", PREIF_NPC, 32'h0000_0000);
    check("wrap_wr", {31'b0, PREIF_Wr}, 32'h1);
    drain("wrap_drain");
    repeat (3) @(negedge clk);
    check("wrap_held_valid", {31'b0, if_valid}, 32'h1);
    check("wrap_held_pc", if_pc, 32'h0000_0000);
    check("wrap_held_instr", if_instr, mem_word(32'h0000_0000));

`ifdef PC_ALIGN_CHECK_EN
    // misaligned redirect target
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0002;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("adel_valid", {31'b0, if_valid}, 32'h1);
    check("adel_flag", {31'b0, if_adel}, 32'h1);
    check("adel_pc", if_pc, 32'h8000_0002);
    check("adel_instr", if_instr, 32'h0);
    check("adel_no_req", {31'b0, icache_req_valid}, 32'h0);
    check("adel_no_wr", {31'b0, PREIF_Wr}, 32'h0);
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0000;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    wait_hs("adel_resume_addr", 32'h8000_0000, at);
`endif

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
